reg_stat_table_mp: RTL and testbench
====================================

# reg_stat_table_mp

Parametrised register status table (RAT) for the Tomasulo front end: one producer tag per architectural register, multiple CDB clear channels, multi-wide rename, and branch checkpoints with restore. It sits between rename/dispatch, which reads source tags and writes destination tags, and the register file, which takes the write index and enable per CDB channel. CDB clears propagate into live checkpoints, so a restored snapshot never holds a tag whose result has already retired to the RF.

## Interface
- NREG, 32, architectural registers; index width RW = $clog2(NREG)
- TAG_W, 6, tag width
- NCDB, 2, CDB broadcast channels
- NREN, 2, rename slots per cycle; read ports = 2*NREN
- NCKPT, 4, checkpoint slots; ID width CW = $clog2(NCKPT)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- cdb_valid  in  NCDB  broadcast valid per channel
- cdb_tag  in  NCDB x TAG_W  broadcast tag per channel
- rf_rd  out  NCDB x RW  RF write index per channel
- rf_we  out  NCDB  RF write enable per channel
- rs_idx  in  2*NREN x RW  source register indices
- rs_tag  out  2*NREN x TAG_W  pending producer tag
- rs_tag_valid  out  2*NREN  1 = value still pending
- ren_en  in  NREN  rename slot active (slot NREN-1 is youngest)
- ren_rd  in  NREN x RW  destination register
- ren_tag  in  NREN x TAG_W  new producer tag
- ckpt_take  in  1  request snapshot
- ckpt_take_ready  out  1  a free slot exists
- ckpt_take_id  out  CW  slot granted (lowest free)
- ckpt_restore  in  1  restore snapshot
- ckpt_restore_id  in  CW  slot to restore
- ckpt_free_mask  in  NCKPT  release slots (resolve or kill younger)

## Operation
- Entry = {valid, tag}. Register 0 is never tagged: ren_en with ren_rd = 0 is dropped, and entry 0 is hard-wired invalid.
- Reads: combinational from pre-edge table state. There is no CDB or rename bypass; the dispatch stage handles same-cycle forwarding.
- CDB lookup (per channel k): find i with entry[i] == {1, cdb_tag[k]}. On a hit, rf_rd[k] = i and rf_we[k] = cdb_valid[k]. On a miss, rf_rd[k] = 0 and rf_we[k] = 0.
- Clear: on a hit with cdb_valid, entry[i] is cleared at the edge, unless a rename slot writes rd == i in the same cycle. The rename always wins.
- Rename: entry[ren_rd[j]] <= {1, ren_tag[j]}. When slots collide on the same rd, the highest j wins.
- Checkpoint take, when ckpt_take && ckpt_take_ready: the slot is marked live and captures the post-edge table, i.e. including same-cycle CDB clears and renames.
- Checkpoint maintenance: every CDB clear (tag match, cdb_valid) also clears the matching entry in every live slot.
- Restore: the table loads snapshot[ckpt_restore_id] with same-cycle CDB clears applied. Same-cycle ren_en and ckpt_take are ignored. The restored slot plus ckpt_free_mask slots become free.
- Free: ckpt_free_mask slots become free at the edge. Freeing a non-live slot is a no-op. A take to a slot freed in the same cycle is not allowed, because ckpt_take_ready/id use pre-edge state.
- Illegal (simulation assertions only): two valid CDB channels with the same tag; restore of a non-live slot; ren_tag equal to a tag already in the table.

## Timing
- Reset, asynchronous: all entries and snapshots invalid, all slots free. Resulting outputs: rs_tag_valid = 0, rs_tag = 0, rf_we = 0, rf_rd = 0, ckpt_take_ready = 1, ckpt_take_id = 0.
- rf_rd/rf_we: same cycle as cdb_valid (combinational).
- Rename or clear is visible on the read ports in the cycle after the edge.
- A snapshot taken in cycle N can be restored from cycle N+1 onward. The restored state is visible in cycle N+1 after the restore.
- Reset during a restore or take: reset dominates and nothing is captured.

## Structure
- Package rst_pkg holds the default parameter values, typedef rst_entry_t {logic valid; logic [TAG_W-1:0] tag;}, and the ckpt_id_t width helper.
- Sub-module rst_tag_cam is one instance per CDB channel. It is a combinational tag-match returning hit and index, and is reused for the table and for each snapshot clear.
- A first-free priority encoder generates ckpt_take_id inline.

## Test plan
- Reset, then rename r5 <- tag 0x12; next cycle rs_idx = 5 gives valid = 1, tag = 0x12. CDB tag 0x12 then gives rf_rd = 5 and rf_we = 1 the same cycle; the following cycle reads invalid.
- Two CDB channels, tags 0x03 (r1) and 0x07 (r9) in the same cycle: both rf_we = 1 with rf_rd = {1, 9}, and both entries clear.
- Rename r4 <- 0x21 in the same cycle as CDB 0x20, where r4 held 0x20: rf_we = 1 and rf_rd = 4, and r4 keeps 0x21.
- Both rename slots write r7 (0x30, 0x31): r7 = 0x31. A rename to r0: r0 stays invalid. An unknown CDB tag gives rf_we = 0 and rf_rd = 0.
- Take ckpt (id 0) with r2 = 0x0A; rename r2 <- 0x0B; CDB 0x0A; restore id 0: r2 is invalid, not 0x0A, and slot 0 is free.
- Fill all 4 slots: ckpt_take_ready = 0. ckpt_free_mask = 0b0100: ready = 1 next cycle with id = 2. Assert rst mid-sequence: all slots are free and all entries invalid immediately.

Source files
------------

// File: rtl/reg_stat_table_mp_pkg.sv
// Shared defaults and types for the register status table and its tag CAM.
package rst_pkg;

   localparam int unsigned RST_NREG  = 32;
   localparam int unsigned RST_TAG_W = 6;
   localparam int unsigned RST_NCDB  = 2;
   localparam int unsigned RST_NREN  = 2;
   localparam int unsigned RST_NCKPT = 4;

   typedef struct packed {
      logic                 valid;
      logic [RST_TAG_W-1:0] tag;
   } rst_entry_t;

   // A single checkpoint slot still needs a 1-bit ID port.
   function automatic int unsigned ckpt_id_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   typedef logic [ckpt_id_w(RST_NCKPT)-1:0] ckpt_id_t;

endpackage

// File: rtl/reg_stat_table_mp_tag_cam.sv
// Combinational tag match over one table image: reports a hit and the matching register index.
module rst_tag_cam #(
   parameter int unsigned NREG  = 32,
   parameter int unsigned TAG_W = 6,
   parameter int unsigned RW    = 5
) (
   input  logic [NREG-1:0]            valid,
   input  logic [NREG-1:0][TAG_W-1:0] tags,
   input  logic [TAG_W-1:0]           key,
   output logic                       hit,
   output logic [RW-1:0]              idx
);

   always_comb begin
      hit = 1'b0;
      idx = '0;
      for (int unsigned i = 0; i < NREG; i++) begin
         if (!hit && valid[i] && (tags[i] == key)) begin
            hit = 1'b1;
            idx = RW'(i);
         end
      end
   end

endmodule

// File: rtl/reg_stat_table_mp.sv
// Register status table: per-register producer tags, CDB clears, multi-wide rename
// and branch checkpoints whose snapshots also observe CDB clears.
module reg_stat_table_mp
   import rst_pkg::*;
#(
   parameter int unsigned NREG  = RST_NREG,
   parameter int unsigned TAG_W = RST_TAG_W,
   parameter int unsigned NCDB  = RST_NCDB,
   parameter int unsigned NREN  = RST_NREN,
   parameter int unsigned NCKPT = RST_NCKPT,
   parameter int unsigned RW    = $clog2(NREG),
   parameter int unsigned CW    = ckpt_id_w(NCKPT)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NCDB-1:0]                  cdb_valid,
   input  logic [NCDB-1:0][TAG_W-1:0]       cdb_tag,
   output logic [NCDB-1:0][RW-1:0]          rf_rd,
   output logic [NCDB-1:0]                  rf_we,
   input  logic [2*NREN-1:0][RW-1:0]        rs_idx,
   output logic [2*NREN-1:0][TAG_W-1:0]     rs_tag,
   output logic [2*NREN-1:0]                rs_tag_valid,
   input  logic [NREN-1:0]                  ren_en,
   input  logic [NREN-1:0][RW-1:0]          ren_rd,
   input  logic [NREN-1:0][TAG_W-1:0]       ren_tag,
   input  logic                             ckpt_take,
   output logic                             ckpt_take_ready,
   output logic [CW-1:0]                    ckpt_take_id,
   input  logic                             ckpt_restore,
   input  logic [CW-1:0]                    ckpt_restore_id,
   input  logic [NCKPT-1:0]                 ckpt_free_mask
);

   logic [NREG-1:0]                        tbl_v, nxt_v;
   logic [NREG-1:0][TAG_W-1:0]             tbl_t, nxt_t;
   logic [NCKPT-1:0][NREG-1:0]             snap_v, snap_nv;
   logic [NCKPT-1:0][NREG-1:0][TAG_W-1:0]  snap_t, snap_nt;
   logic [NCKPT-1:0]                       live, live_n;

   logic [NCDB-1:0]                        tbl_hit;
   logic [NCDB-1:0][RW-1:0]                tbl_idx;
   logic [NCKPT-1:0][NCDB-1:0]             snp_hit;
   logic [NCKPT-1:0][NCDB-1:0][RW-1:0]     snp_idx;
   logic                                   take_go;

   for (genvar k = 0; k < NCDB; k++) begin : g_cdb
      rst_tag_cam #(.NREG(NREG), .TAG_W(TAG_W), .RW(RW)) u_tbl_cam (
         .valid (tbl_v),
         .tags  (tbl_t),
         .key   (cdb_tag[k]),
         .hit   (tbl_hit[k]),
         .idx   (tbl_idx[k])
      );
      assign rf_we[k] = cdb_valid[k] & tbl_hit[k];
      assign rf_rd[k] = tbl_idx[k];

      for (genvar s = 0; s < NCKPT; s++) begin : g_snap
         rst_tag_cam #(.NREG(NREG), .TAG_W(TAG_W), .RW(RW)) u_snap_cam (
            .valid (snap_v[s]),
            .tags  (snap_t[s]),
            .key   (cdb_tag[k]),
            .hit   (snp_hit[s][k]),
            .idx   (snp_idx[s][k])
         );
      end
   end

   always_comb begin
      for (int unsigned p = 0; p < 2*NREN; p++) begin
         rs_tag_valid[p] = tbl_v[rs_idx[p]];
         rs_tag[p]       = tbl_v[rs_idx[p]] ? tbl_t[rs_idx[p]] : '0;
      end
   end

   // Lowest free checkpoint slot.
   always_comb begin
      ckpt_take_ready = ~&live;
      ckpt_take_id    = '0;
      for (int unsigned i = NCKPT; i > 0; i--) begin
         if (!live[i-1]) ckpt_take_id = CW'(i-1);
      end
   end

   assign take_go = ckpt_take && ckpt_take_ready && !ckpt_restore;

   // Post-edge table image; a restore starts from the snapshot and drops same-cycle renames.
   always_comb begin
      if (ckpt_restore) begin
         nxt_v = snap_v[ckpt_restore_id];
         nxt_t = snap_t[ckpt_restore_id];
         for (int unsigned k = 0; k < NCDB; k++) begin
            if (cdb_valid[k] && snp_hit[ckpt_restore_id][k])
               nxt_v[snp_idx[ckpt_restore_id][k]] = 1'b0;
         end
      end else begin
         nxt_v = tbl_v;
         nxt_t = tbl_t;
         for (int unsigned k = 0; k < NCDB; k++) begin
            if (cdb_valid[k] && tbl_hit[k]) nxt_v[tbl_idx[k]] = 1'b0;
         end
         for (int unsigned j = 0; j < NREN; j++) begin
            if (ren_en[j] && (ren_rd[j] != '0)) begin
               nxt_v[ren_rd[j]] = 1'b1;
               nxt_t[ren_rd[j]] = ren_tag[j];
            end
         end
      end
      nxt_v[0] = 1'b0;
   end

   always_comb begin
      snap_nv = snap_v;
      snap_nt = snap_t;
      for (int unsigned s = 0; s < NCKPT; s++) begin
         for (int unsigned k = 0; k < NCDB; k++) begin
            if (live[s] && cdb_valid[k] && snp_hit[s][k]) snap_nv[s][snp_idx[s][k]] = 1'b0;
         end
      end
      if (take_go) begin
         snap_nv[ckpt_take_id] = nxt_v;
         snap_nt[ckpt_take_id] = nxt_t;
      end
      live_n = live & ~ckpt_free_mask;
      if (ckpt_restore) live_n[ckpt_restore_id] = 1'b0;
      if (take_go)      live_n[ckpt_take_id]    = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tbl_v  <= '0;
         tbl_t  <= '0;
         snap_v <= '0;
         snap_t <= '0;
         live   <= '0;
      end else begin
         tbl_v  <= nxt_v;
         tbl_t  <= nxt_t;
         snap_v <= snap_nv;
         snap_t <= snap_nt;
         live   <= live_n;
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int unsigned a = 0; a < NCDB; a++) begin
            for (int unsigned b = a + 1; b < NCDB; b++) begin
               assert (!(cdb_valid[a] && cdb_valid[b] && (cdb_tag[a] == cdb_tag[b])))
                  else $error("two CDB channels carry the same tag");
            end
         end
         if (ckpt_restore) begin
            assert (live[ckpt_restore_id]) else $error("restore of a non-live checkpoint");
         end else begin
            for (int unsigned j = 0; j < NREN; j++) begin
               for (int unsigned i = 0; i < NREG; i++) begin
                  assert (!(ren_en[j] && (ren_rd[j] != '0) && tbl_v[i] && (tbl_t[i] == ren_tag[j])))
                     else $error("rename tag already present in the table");
               end
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_reg_stat_table_mp.sv
// Directed bench for reg_stat_table_mp: per-cycle vector table plus checkpoint and reset sequences.
module tb_reg_stat_table_mp;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [1:0]           cdb_valid;
   logic [1:0][5:0]      cdb_tag;
   logic [1:0][4:0]      rf_rd;
   logic [1:0]           rf_we;
   logic [3:0][4:0]      rs_idx;
   logic [3:0][5:0]      rs_tag;
   logic [3:0]           rs_tag_valid;
   logic [1:0]           ren_en;
   logic [1:0][4:0]      ren_rd;
   logic [1:0][5:0]      ren_tag;
   logic                 ckpt_take;
   logic                 ckpt_take_ready;
   logic [1:0]           ckpt_take_id;
   logic                 ckpt_restore;
   logic [1:0]           ckpt_restore_id;
   logic [3:0]           ckpt_free_mask;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   reg_stat_table_mp #(.NREG(32), .TAG_W(6), .NCDB(2), .NREN(2), .NCKPT(4)) dut (
      .clk             (clk),
      .rst             (rst),
      .cdb_valid       (cdb_valid),
      .cdb_tag         (cdb_tag),
      .rf_rd           (rf_rd),
      .rf_we           (rf_we),
      .rs_idx          (rs_idx),
      .rs_tag          (rs_tag),
      .rs_tag_valid    (rs_tag_valid),
      .ren_en          (ren_en),
      .ren_rd          (ren_rd),
      .ren_tag         (ren_tag),
      .ckpt_take       (ckpt_take),
      .ckpt_take_ready (ckpt_take_ready),
      .ckpt_take_id    (ckpt_take_id),
      .ckpt_restore    (ckpt_restore),
      .ckpt_restore_id (ckpt_restore_id),
      .ckpt_free_mask  (ckpt_free_mask)
   );

   typedef struct {
      logic [1:0] ren_en;
      logic [4:0] rd0, rd1;
      logic [5:0] tg0, tg1;
      logic [1:0] cv;
      logic [5:0] ct0, ct1;
      logic [4:0] ri0, ri1;
      logic [1:0] e_we;
      logic [4:0] e_rd0, e_rd1;
      logic       e_v0, e_v1;
      logic [5:0] e_t0, e_t1;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic idle();
      cdb_valid       = '0;
      cdb_tag         = '0;
      rs_idx          = '0;
      ren_en          = '0;
      ren_rd          = '0;
      ren_tag         = '0;
      ckpt_take       = 1'b0;
      ckpt_restore    = 1'b0;
      ckpt_restore_id = '0;
      ckpt_free_mask  = '0;
   endtask

   // Inputs change just after the active edge; outputs are sampled at the falling edge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
      idle();
   endtask

   initial begin
      // ren_en, rd0, rd1, tg0, tg1, cv, ct0, ct1, ri0, ri1, e_we, e_rd0, e_rd1, e_v0, e_v1, e_t0, e_t1
      vecs[0]  = '{2'b00, 5'd0, 5'd0, 6'h00, 6'h00, 2'b00, 6'h00, 6'h00, 5'd5, 5'd0, 2'b00, 5'd0, 5'd0, 1'b0, 1'b0, 6'h00, 6'h00};
      vecs[1]  = '{2'b01, 5'd5, 5'd0, 6'h12, 6'h00, 2'b00, 6'h00, 6'h00, 5'd5, 5'd0, 2'b00, 5'd0, 5'd0, 1'b0, 1'b0, 6'h00, 6'h00};
      vecs[2]  = '{2'b00, 5'd0, 5'd0, 6'h00, 6'h00, 2'b00, 6'h00, 6'h00, 5'd5, 5'd0, 2'b00, 5'd0, 5'd0, 1'b1, 1'b0, 6'h12, 6'h00};
      vecs[3]  = '{2'b00, 5'd0, 5'd0, 6'h00, 6'h00, 2'b01, 6'h12, 6'h00, 5'd5, 5'd0, 2'b01, 5'd5, 5'd0, 1'b1, 1'b0, 6'h12, 6'h00};
      vecs[4]  = '{2'b00, 5'd0, 5'd0, 6'h00, 6'h00, 2'b00, 6'h00, 6'h00, 5'd5, 5'd0, 2'b00, 5'd0, 5'd0, 1'b0, 1'b0, 6'h00, 6'h00};
      vecs[5]  = '{2'b11, 5'd1, 5'd9, 6'h03, 6'h07, 2'b00, 6'h00, 6'h00, 5'd1, 5'd9, 2'b00, 5'd0, 5'd0, 1'b0, 1'b0, 6'h00, 6'h00};
      vecs[6]  = '{2'b00, 5'd0, 5'd0, 6'h00, 6'h00, 2'b11, 6'h03, 6'h07, 5'd1, 5'd9, 2'b11, 5'd1, 5'd9, 1'b1, 1'b1, 6'h03, 6'h07};
      vecs[7]  = '{2'b00, 5'd0, 5'd0, 6'h00, 6'h00, 2'b00, 6'h00, 6'h00, 5'd1, 5'd9, 2'b00, 5'd0, 5'd0, 1'b0, 1'b0, 6'h00, 6'h00};
      vecs[8]  = '{2'b01, 5'd4, 5'd0, 6'h20, 6'h00, 2'b00, 6'h00, 6'h00, 5'd4, 5'd0, 2'b00, 5'd0, 5'd0, 1'b0, 1'b0, 6'h00, 6'h00};
      vecs[9]  = '{2'b01, 5'd4, 5'd0, 6'h21, 6'h00, 2'b01, 6'h20, 6'h00, 5'd4, 5'd0, 2'b01, 5'd4, 5'd0, 1'b1, 1'b0, 6'h20, 6'h00};
      vecs[10] = '{2'b00, 5'd0, 5'd0, 6'h00, 6'h00, 2'b00, 6'h00, 6'h00, 5'd4, 5'd0, 2'b00, 5'd0, 5'd0, 1'b1, 1'b0, 6'h21, 6'h00};
      vecs[11] = '{2'b11, 5'd7, 5'd7, 6'h30, 6'h31, 2'b00, 6'h00, 6'h00, 5'd7, 5'd4, 2'b00, 5'd0, 5'd0, 1'b0, 1'b1, 6'h00, 6'h21};
      vecs[12] = '{2'b01, 5'd0, 5'd0, 6'h33, 6'h00, 2'b00, 6'h00, 6'h00, 5'd7, 5'd0, 2'b00, 5'd0, 5'd0, 1'b1, 1'b0, 6'h31, 6'h00};
      vecs[13] = '{2'b00, 5'd0, 5'd0, 6'h00, 6'h00, 2'b11, 6'h33, 6'h3F, 5'd0, 5'd7, 2'b00, 5'd0, 5'd0, 1'b0, 1'b1, 6'h00, 6'h31};
      vecs[14] = '{2'b00, 5'd0, 5'd0, 6'h00, 6'h00, 2'b11, 6'h21, 6'h31, 5'd4, 5'd7, 2'b11, 5'd4, 5'd7, 1'b1, 1'b1, 6'h21, 6'h31};
      vecs[15] = '{2'b00, 5'd0, 5'd0, 6'h00, 6'h00, 2'b00, 6'h00, 6'h00, 5'd4, 5'd7, 2'b00, 5'd0, 5'd0, 1'b0, 1'b0, 6'h00, 6'h00};

      idle();
      rs_idx[0] = 5'd5;
      #12;
      chk("reset rs_tag_valid", 32'(rs_tag_valid), 32'h0);
      chk("reset rs_tag", 32'(rs_tag), 32'h0);
      chk("reset rf_we", 32'(rf_we), 32'h0);
      chk("reset rf_rd", 32'(rf_rd), 32'h0);
      chk("reset take_ready", 32'(ckpt_take_ready), 32'h1);
      chk("reset take_id", 32'(ckpt_take_id), 32'h0);
      rst = 1'b0;

      for (int v = 0; v < 16; v++) begin
         next_cycle();
         ren_en     = vecs[v].ren_en;
         ren_rd[0]  = vecs[v].rd0;
         ren_rd[1]  = vecs[v].rd1;
         ren_tag[0] = vecs[v].tg0;
         ren_tag[1] = vecs[v].tg1;
         cdb_valid  = vecs[v].cv;
         cdb_tag[0] = vecs[v].ct0;
         cdb_tag[1] = vecs[v].ct1;
         rs_idx[0]  = vecs[v].ri0;
         rs_idx[1]  = vecs[v].ri1;
         @(negedge clk);
         chk($sformatf("v%0d rf_we", v), 32'(rf_we), 32'(vecs[v].e_we));
         chk($sformatf("v%0d rf_rd0", v), 32'(rf_rd[0]), 32'(vecs[v].e_rd0));
         chk($sformatf("v%0d rf_rd1", v), 32'(rf_rd[1]), 32'(vecs[v].e_rd1));
         chk($sformatf("v%0d rs_valid0", v), 32'(rs_tag_valid[0]), 32'(vecs[v].e_v0));
         chk($sformatf("v%0d rs_valid1", v), 32'(rs_tag_valid[1]), 32'(vecs[v].e_v1));
         chk($sformatf("v%0d rs_tag0", v), 32'(rs_tag[0]), 32'(vecs[v].e_t0));
         chk($sformatf("v%0d rs_tag1", v), 32'(rs_tag[1]), 32'(vecs[v].e_t1));
      end

      // Checkpoint take, CDB clear into the snapshot, then restore.
      next_cycle();
      ren_en = 2'b11; ren_rd[0] = 5'd2; ren_tag[0] = 6'h0A; ren_rd[1] = 5'd3; ren_tag[1] = 6'h15;
      next_cycle();
      ckpt_take = 1'b1;
      @(negedge clk);
      chk("take ready", 32'(ckpt_take_ready), 32'h1);
      chk("take id0", 32'(ckpt_take_id), 32'h0);
      next_cycle();
      ren_en = 2'b11; ren_rd[0] = 5'd2; ren_tag[0] = 6'h0B; ren_rd[1] = 5'd3; ren_tag[1] = 6'h16;
      @(negedge clk);
      chk("after take id", 32'(ckpt_take_id), 32'h1);
      next_cycle();
      cdb_valid = 2'b01; cdb_tag[0] = 6'h0A;
      rs_idx[0] = 5'd2;
      @(negedge clk);
      chk("stale cdb rf_we", 32'(rf_we), 32'h0);
      chk("r2 renamed tag", 32'(rs_tag[0]), 32'h0B);
      next_cycle();
      ckpt_restore = 1'b1; ckpt_restore_id = 2'd0;
      next_cycle();
      rs_idx[0] = 5'd2; rs_idx[1] = 5'd3;
      @(negedge clk);
      chk("restore r2 valid", 32'(rs_tag_valid[0]), 32'h0);
      chk("restore r3 valid", 32'(rs_tag_valid[1]), 32'h1);
      chk("restore r3 tag", 32'(rs_tag[1]), 32'h15);
      chk("restore slot free", 32'(ckpt_take_id), 32'h0);

      // Fill all slots, free one, then asynchronous reset mid-cycle.
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         ckpt_take = 1'b1;
         @(negedge clk);
         chk($sformatf("fill%0d ready", i), 32'(ckpt_take_ready), 32'h1);
         chk($sformatf("fill%0d id", i), 32'(ckpt_take_id), 32'(i));
      end
      next_cycle();
      ckpt_free_mask = 4'b0100;
      @(negedge clk);
      chk("full ready", 32'(ckpt_take_ready), 32'h0);
      next_cycle();
      rs_idx[0] = 5'd3;
      @(negedge clk);
      chk("freed ready", 32'(ckpt_take_ready), 32'h1);
      chk("freed id", 32'(ckpt_take_id), 32'h2);
      chk("pre-reset r3 valid", 32'(rs_tag_valid[0]), 32'h1);
      #2 rst = 1'b1;
      #1;
      chk("async rst ready", 32'(ckpt_take_ready), 32'h1);
      chk("async rst id", 32'(ckpt_take_id), 32'h0);
      chk("async rst r3 valid", 32'(rs_tag_valid[0]), 32'h0);
      chk("async rst r3 tag", 32'(rs_tag[0]), 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
